// File: rtl/pke.sv
// ---------------------------------------------------------------------------
// pke -- packet key extractor
//
// Parses the metadata word (word 0) and the Ethernet header word (word 1) of
// each packet. It produces a 102-bit lookup key {DMAC, SMAC, inport} and a
// 3-bit packet type. Each accepted word is forwarded with a fixed two-cycle
// delay, so the key is already stable when the packet reaches the next stage.
// A word that arrives while the parser is idle and is not a head word is
// dropped and counted.
//
// Build option:
//   PKE_PTP_VLAN_EN  when defined, a VLAN-tagged frame whose inner ethertype
//                    is 16'h88F7 is classified as PTP (type 2).
//
// Ports:
//   clk               clock; all logic runs on the rising edge
//   rst               asynchronous, active-high reset
//   in_pke_data       packet word {hdr[1:0], byte count[3:0], payload[127:0]}
//   in_pke_data_wr    in_pke_data is valid this cycle
//   in_pke_valid      packet-good flag, arrives with the tail word
//   in_pke_valid_wr   strobe for in_pke_valid
//   out_pke_data      packet word, delayed by two cycles
//   out_pke_data_wr   out_pke_data is valid
//   out_pke_valid     delayed packet-good flag
//   out_pke_valid_wr  delayed packet-good strobe
//   out_pke_pkttype   0 other, 1 VLAN-tagged, 2 PTP
//   out_pke_key       {DMAC[101:54], SMAC[53:6], inport[5:0]}
//   pke_err_cnt       saturating count of dropped words
// ---------------------------------------------------------------------------
module pke (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_pke_data,
  input  logic         in_pke_data_wr,
  input  logic         in_pke_valid,
  input  logic         in_pke_valid_wr,
  output logic [133:0] out_pke_data,
  output logic         out_pke_data_wr,
  output logic         out_pke_valid,
  output logic         out_pke_valid_wr,
  output logic [2:0]   out_pke_pkttype,
  output logic [101:0] out_pke_key,
  output logic [15:0]  pke_err_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  localparam logic [1:0]  HDR_HEAD  = 2'b01;
  localparam logic [1:0]  HDR_TAIL  = 2'b10;
  localparam logic [15:0] ETH_VLAN  = 16'h8100;
  localparam logic [15:0] ETH_PTP   = 16'h88F7;

  state_t       state_reg, state_next;
  logic         accept;
  logic         discard;
  logic         hdr_cap;
  logic [1:0]   word_hdr;
  logic [15:0]  outer_type;
  logic [2:0]   pkttype_next;
  logic [5:0]   inport_reg;

  logic [133:0] s1_data_reg;
  logic         s1_wr_reg;
  logic         s1_valid_reg;
  logic         s1_valid_wr_reg;

  assign word_hdr   = in_pke_data[133:132];
  assign outer_type = in_pke_data[31:16];

  // Parser: decides whether the current word is accepted or dropped.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    discard    = 1'b0;
    hdr_cap    = 1'b0;
    if (in_pke_data_wr) begin
      case (state_reg)
        IDLE: begin
          if (word_hdr == HDR_HEAD) begin
            accept     = 1'b1;
            state_next = HDR;
          end else begin
            discard = 1'b1;
          end
        end
        HDR: begin
          accept     = 1'b1;
          hdr_cap    = 1'b1;
          state_next = (word_hdr == HDR_TAIL) ? IDLE : BODY;
        end
        BODY: begin
          accept = 1'b1;
          if (word_hdr == HDR_TAIL) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Classify the packet from the ethertype field(s) of the header word.
  always_comb begin
    pkttype_next = 3'd0;
    if (outer_type == ETH_PTP) begin
      pkttype_next = 3'd2;
    end else if (outer_type == ETH_VLAN) begin
      pkttype_next = 3'd1;
`ifdef PKE_PTP_VLAN_EN
      if (in_pke_data[15:0] == ETH_PTP) begin
        pkttype_next = 3'd2;
      end
`endif
    end
  end

  // The inport is taken from the metadata word and held until the header
  // word arrives. The key and type then change only on that word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inport_reg      <= 6'd0;
      out_pke_key     <= 102'd0;
      out_pke_pkttype <= 3'd0;
    end else begin
      if (accept && (state_reg == IDLE)) begin
        inport_reg <= in_pke_data[101:96];
      end
      if (hdr_cap) begin
        out_pke_key     <= {in_pke_data[127:80], in_pke_data[79:32], inport_reg};
        out_pke_pkttype <= pkttype_next;
      end
    end
  end

  // Two-stage delay line. It shifts every cycle, so input gaps are
  // reproduced exactly. Dropped words enter as empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_reg      <= 134'd0;
      s1_wr_reg        <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s1_valid_wr_reg  <= 1'b0;
      out_pke_data     <= 134'd0;
      out_pke_data_wr  <= 1'b0;
      out_pke_valid    <= 1'b0;
      out_pke_valid_wr <= 1'b0;
    end else begin
      s1_data_reg      <= accept ? in_pke_data : 134'd0;
      s1_wr_reg        <= accept;
      s1_valid_reg     <= in_pke_valid & accept;
      s1_valid_wr_reg  <= in_pke_valid_wr & accept;
      out_pke_data     <= s1_data_reg;
      out_pke_data_wr  <= s1_wr_reg;
      out_pke_valid    <= s1_valid_reg;
      out_pke_valid_wr <= s1_valid_wr_reg;
    end
  end

  // The error counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pke_err_cnt <= 16'd0;
    end else if (discard && (pke_err_cnt != 16'hFFFF)) begin
      pke_err_cnt <= pke_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pke.sv
// ---------------------------------------------------------------------------
// tb_pke -- self-checking bench for pke.
// Each accepted word pushes its expected output and arrival cycle onto a
// scoreboard queue. The output monitor pops an entry and compares it
// whenever out_pke_data_wr is high.
// ---------------------------------------------------------------------------
module tb_pke;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] in_pke_data;
  logic         in_pke_data_wr;
  logic         in_pke_valid;
  logic         in_pke_valid_wr;
  logic [133:0] out_pke_data;
  logic         out_pke_data_wr;
  logic         out_pke_valid;
  logic         out_pke_valid_wr;
  logic [2:0]   out_pke_pkttype;
  logic [101:0] out_pke_key;
  logic [15:0]  pke_err_cnt;

  pke dut (
    .clk              (clk),
    .rst              (rst),
    .in_pke_data      (in_pke_data),
    .in_pke_data_wr   (in_pke_data_wr),
    .in_pke_valid     (in_pke_valid),
    .in_pke_valid_wr  (in_pke_valid_wr),
    .out_pke_data     (out_pke_data),
    .out_pke_data_wr  (out_pke_data_wr),
    .out_pke_valid    (out_pke_valid),
    .out_pke_valid_wr (out_pke_valid_wr),
    .out_pke_pkttype  (out_pke_pkttype),
    .out_pke_key      (out_pke_key),
    .pke_err_cnt      (pke_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [133:0] data;
    logic         valid;
    logic         vwr;
    logic [101:0] key;
    logic [2:0]   ptype;
    int           at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_err = 16'd0;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_pke_data_wr) begin
        if (sb.size() == 0) begin
          check("spurious_out", 134'd1, 134'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("out t=%0d data=%h key=%h type=%0d v=%b vwr=%b",
                   cyc, out_pke_data, out_pke_key, out_pke_pkttype,
                   out_pke_valid, out_pke_valid_wr);
          check("latency", cyc, mon_e.at);
          check("data", out_pke_data, mon_e.data);
          check("valid", out_pke_valid, mon_e.valid);
          check("valid_wr", out_pke_valid_wr, mon_e.vwr);
          check("key", out_pke_key, mon_e.key);
          check("pkttype", out_pke_pkttype, mon_e.ptype);
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_e = sb.pop_front();
        check("missing_out", cyc, mon_e.at);
      end
    end
  end

  task automatic put(input logic [133:0] d, input logic wr, input logic v, input logic vwr);
    @(posedge clk);
    #1;
    in_pke_data     = d;
    in_pke_data_wr  = wr;
    in_pke_valid    = v;
    in_pke_valid_wr = vwr;
  endtask

  task automatic idle(input int n);
    repeat (n) put(134'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [133:0] pkt_word(input int i, input int nw, input logic [5:0] inport,
                                            input logic [47:0] dmac, input logic [47:0] smac,
                                            input logic [15:0] et, input logic [15:0] inner);
    logic [133:0] w;
    if (i == 0)
      w = {2'b01, 4'h0, 26'h155_5555, inport, 32'hDEAD_BEEF, 64'h0};
    else if (i == 1)
      w = {2'b11, 4'h0, dmac, smac, et, inner};
    else
      w = {((i == nw - 1) ? 2'b10 : 2'b11), 4'hF, $urandom(), $urandom(), $urandom(), $urandom()};
    return w;
  endfunction

  task automatic send_pkt(input logic [5:0] inport, input logic [47:0] dmac, input logic [47:0] smac,
                          input logic [15:0] et, input logic [15:0] inner, input int nw,
                          input logic [2:0] ptype);
    logic [133:0] w;
    logic         tail;
    exp_t         e;
    for (int i = 0; i < nw; i++) begin
      w    = pkt_word(i, nw, inport, dmac, smac, et, inner);
      tail = (i == nw - 1);
      put(w, 1'b1, tail, tail);
      e.data  = w;
      e.valid = tail;
      e.vwr   = tail;
      e.key   = {dmac, smac, inport};
      e.ptype = ptype;
      e.at    = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic stray();
    put({2'b11, 4'h0, 128'h0}, 1'b1, 1'b0, 1'b0);
    if (exp_err != 16'hFFFF) exp_err++;
  endtask

  localparam logic [47:0] DMAC_A = 48'h0102_0304_0506;
  localparam logic [47:0] SMAC_A = 48'h0A0B_0C0D_0E0F;

`ifdef PKE_PTP_VLAN_EN
  localparam logic [2:0] VLAN_PTP_TYPE = 3'd2;
`else
  localparam logic [2:0] VLAN_PTP_TYPE = 3'd1;
`endif

  logic [133:0] w;
  exp_t         e0;

  initial begin
    rst             = 1'b1;
    in_pke_data     = '0;
    in_pke_data_wr  = 1'b0;
    in_pke_valid    = 1'b0;
    in_pke_valid_wr = 1'b0;
    #1;
    check("rst_data", out_pke_data, 134'd0);
    check("rst_wr", out_pke_data_wr, 134'd0);
    check("rst_valid", out_pke_valid, 134'd0);
    check("rst_vwr", out_pke_valid_wr, 134'd0);
    check("rst_type", out_pke_pkttype, 134'd0);
    check("rst_key", out_pke_key, 134'd0);
    check("rst_err", pke_err_cnt, 134'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic 4-word IPv4 packet, then the key must hold across an idle gap.
    send_pkt(6'h2, DMAC_A, SMAC_A, 16'h0800, 16'h0000, 4, 3'd0);
    idle(5);
    check("key_hold_gap", out_pke_key, {DMAC_A, SMAC_A, 6'h2});
    check("err_none", pke_err_cnt, exp_err);

    // Ethertype classification.
    send_pkt(6'h05, 48'hAAAA_BBBB_CCCC, 48'h1111_2222_3333, 16'h88F7, 16'h0000, 3, 3'd2);
    idle(2);
    send_pkt(6'h06, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFE, 16'h8100, 16'h88F7, 3, VLAN_PTP_TYPE);
    idle(2);
    send_pkt(6'h07, 48'h1234_5678_9ABC, 48'hCBA9_8765_4321, 16'h8100, 16'h0800, 4, 3'd1);
    idle(2);
    send_pkt(6'h08, 48'h5555_5555_5555, 48'h6666_6666_6666, 16'h88F8, 16'h88F7, 3, 3'd0);
    idle(2);

    // Back-to-back packets A and B with no gap between them.
    send_pkt(6'h3, 48'hA0A0_A0A0_A0A0, 48'hA1A1_A1A1_A1A1, 16'h0800, 16'h0, 5, 3'd0);
    send_pkt(6'h1, 48'hB0B0_B0B0_B0B0, 48'hB1B1_B1B1_B1B1, 16'h88F7, 16'h0, 3, 3'd2);
    idle(4);

    // Three stray body words while idle, then a normal packet.
    repeat (3) stray();
    idle(3);
    check("err_strays", pke_err_cnt, exp_err);
    send_pkt(6'h3F, 48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000, 16'h0800, 16'h0, 3, 3'd0);
    idle(4);

    // Reset asserted while word 2 of a 5-word packet is being presented.
    for (int i = 0; i < 2; i++) begin
      w = pkt_word(i, 5, 6'h09, 48'h0909_0909_0909, 48'h9090_9090_9090, 16'h88F7, 16'h0);
      put(w, 1'b1, 1'b0, 1'b0);
      e0.data = w; e0.valid = 1'b0; e0.vwr = 1'b0;
      e0.key = {48'h0909_0909_0909, 48'h9090_9090_9090, 6'h09};
      e0.ptype = 3'd2; e0.at = cyc + 2;
      sb.push_back(e0);
    end
    @(posedge clk);
    #1;
    in_pke_data    = pkt_word(2, 5, 6'h09, 48'h0, 48'h0, 16'h0, 16'h0);
    in_pke_data_wr = 1'b1;
    rst            = 1'b1;
    #1;
    sb.delete();
    exp_err = 16'd0;
    check("mrst_data", out_pke_data, 134'd0);
    check("mrst_wr", out_pke_data_wr, 134'd0);
    check("mrst_valid", out_pke_valid, 134'd0);
    check("mrst_vwr", out_pke_valid_wr, 134'd0);
    check("mrst_type", out_pke_pkttype, 134'd0);
    check("mrst_key", out_pke_key, 134'd0);
    check("mrst_err", pke_err_cnt, 134'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    in_pke_data    = pkt_word(3, 5, 6'h09, 48'h0, 48'h0, 16'h0, 16'h0);
    in_pke_data_wr = 1'b1;
    exp_err++;
    put(pkt_word(4, 5, 6'h09, 48'h0, 48'h0, 16'h0, 16'h0), 1'b1, 1'b1, 1'b1);
    exp_err++;
    idle(3);
    check("err_after_rst", pke_err_cnt, exp_err);
    send_pkt(6'h0C, 48'hC0FF_EE00_1122, 48'h3344_5566_7788, 16'h8100, 16'h88F7, 4, VLAN_PTP_TYPE);
    idle(4);

    // Saturation of the error counter.
    repeat (65535) stray();
    idle(2);
    check("err_sat", pke_err_cnt, 16'hFFFF);
    repeat (3) stray();
    idle(2);
    check("err_sat_hold", pke_err_cnt, exp_err);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    check("drain", sb.size(), 134'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
